// File: rtl/sysid_probe_pkg.sv
// rtl/sysid_probe_pkg.sv - shared types and constants for the sysid probe master
package sysid_probe_pkg;

   typedef logic [31:0] data_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ_ID,
      WAIT_ID,
      REQ_TS,
      WAIT_TS,
      DONE
   } state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_probe_if.sv
// rtl/sysid_probe_if.sv - Avalon-MM read bus between the probe master and the sysid slave
interface sysid_probe_if;
   import sysid_probe_pkg::*;

   logic  avm_address;
   logic  avm_read;
   logic  avm_waitrequest;
   data_t avm_readdata;
   logic  avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );

endinterface

// File: rtl/sysid_probe_watchdog.sv
// rtl/sysid_probe_watchdog.sv - per-transaction cycle counter, expires on the LIMIT-th enabled cycle
module sysid_probe_watchdog #(
   parameter logic [15:0] LIMIT = 16'd255
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [15:0] r_count;

   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_count <= 16'd0;
      end else if (i_enable) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_expired = i_enable && (r_count == LIMIT - 16'd1);

endmodule

// File: rtl/sysid_probe_master.sv
// rtl/sysid_probe_master.sv - reads sysid ID and timestamp words and checks them against expected values
// Optional watchdog: define SYSID_PROBE_TIMEOUT_EN.
module sysid_probe_master
   import sysid_probe_pkg::*;
#(
   parameter data_t       EXPECTED_ID    = 32'd0,
   parameter data_t       EXPECTED_TS    = 32'd1413707058,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   sysid_probe_if.master avm,
   output logic          busy,
   output logic          done,
   output data_t         sysid_id,
   output data_t         sysid_ts,
   output logic          id_match,
   output logic          ts_match,
   output logic          timeout_err
);

   state_t r_state;
   state_t w_next;
   data_t  r_sysid_id;
   data_t  r_sysid_ts;
   logic   r_id_match;
   logic   r_ts_match;
   logic   r_timeout_err;
   logic   w_expired;
   logic   w_cap_id;
   logic   w_cap_ts;

`ifdef SYSID_PROBE_TIMEOUT_EN
   logic w_wd_enable;
   logic w_wd_clear;

   assign w_wd_enable = (r_state == REQ_ID) || (r_state == WAIT_ID) ||
                        (r_state == REQ_TS) || (r_state == WAIT_TS);
   // Restart the count when the ID word lands so each transaction gets a full budget.
   assign w_wd_clear  = !w_wd_enable || w_cap_id;

   sysid_probe_watchdog #(
      .LIMIT (16'(TIMEOUT_CYCLES))
   ) u_watchdog (
      .clock     (clock),
      .reset     (reset),
      .i_clear   (w_wd_clear),
      .i_enable  (w_wd_enable),
      .o_expired (w_expired)
   );
   assign timeout_err = r_timeout_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_expired        = 1'b0;
   assign timeout_err      = 1'b0;
`endif

   assign w_cap_id = (r_state == WAIT_ID) && avm.avm_readdatavalid && !w_expired;
   assign w_cap_ts = (r_state == WAIT_TS) && avm.avm_readdatavalid && !w_expired;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      avm.avm_read    = 1'b0;
      avm.avm_address = SYSID_ADDR_ID;
      case (r_state)
         IDLE: begin
            if (start) w_next = REQ_ID;
         end
         REQ_ID: begin
            avm.avm_read    = 1'b1;
            avm.avm_address = SYSID_ADDR_ID;
            if (w_expired)                    w_next = DONE;
            else if (!avm.avm_waitrequest)    w_next = WAIT_ID;
         end
         WAIT_ID: begin
            if (w_expired)     w_next = DONE;
            else if (w_cap_id) w_next = REQ_TS;
         end
         REQ_TS: begin
            avm.avm_read    = 1'b1;
            avm.avm_address = SYSID_ADDR_TS;
            if (w_expired)                    w_next = DONE;
            else if (!avm.avm_waitrequest)    w_next = WAIT_TS;
         end
         WAIT_TS: begin
            if (w_expired || w_cap_ts) w_next = DONE;
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Match flags are settled on the edge into DONE so they are valid alongside the done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sysid_id    <= '0;
         r_sysid_ts    <= '0;
         r_id_match    <= 1'b0;
         r_ts_match    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == IDLE && start) begin
            r_sysid_id    <= '0;
            r_sysid_ts    <= '0;
            r_id_match    <= 1'b0;
            r_ts_match    <= 1'b0;
            r_timeout_err <= 1'b0;
         end
         if (w_cap_id) begin
            r_sysid_id <= avm.avm_readdata;
         end
         if (w_cap_ts) begin
            r_sysid_ts <= avm.avm_readdata;
            r_id_match <= (r_sysid_id == EXPECTED_ID);
            r_ts_match <= (avm.avm_readdata == EXPECTED_TS);
         end
         if (w_expired) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign sysid_id = r_sysid_id;
   assign sysid_ts = r_sysid_ts;
   assign id_match = r_id_match;
   assign ts_match = r_ts_match;

endmodule

// File: tb/tb_sysid_probe_master.sv
// tb/tb_sysid_probe_master.sv - scoreboard bench for sysid_probe_master with a behavioural sysid slave
module tb_sysid_probe_master;

   localparam logic [31:0] TS_GOOD = 32'd1413707058;

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      logic        idm;
      logic        tsm;
      logic        to;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] sysid_id;
   logic [31:0] sysid_ts;
   logic        id_match;
   logic        ts_match;
   logic        timeout_err;

   sysid_probe_if avm_bus ();

   sysid_probe_master #(
      .EXPECTED_ID    (32'd0),
      .EXPECTED_TS    (TS_GOOD),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock       (clk),
      .reset       (rst),
      .start       (start),
      .avm         (avm_bus),
      .busy        (busy),
      .done        (done),
      .sysid_id    (sysid_id),
      .sysid_ts    (sysid_ts),
      .id_match    (id_match),
      .ts_match    (ts_match),
      .timeout_err (timeout_err)
   );

   int          checks;
   int          errors;
   int          cyc;
   int          ndone;
   exp_t        sb[$];
   logic [31:0] mem [2];
   int          g_wait;
   logic [1:0]  g_noresp;
   logic        inject;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Slave: honours g_wait stall cycles per request, answers one cycle after acceptance.
   initial begin
      int   wcnt;
      logic pend;
      logic paddr;
      logic prev_stall;
      logic prev_addr;
      wcnt = 0; pend = 1'b0; paddr = 1'b0; prev_stall = 1'b0; prev_addr = 1'b0;
      avm_bus.avm_waitrequest   = 1'b0;
      avm_bus.avm_readdatavalid = 1'b0;
      avm_bus.avm_readdata      = '0;
      forever begin
         @(negedge clk);
         avm_bus.avm_readdatavalid = 1'b0;
         if (rst) begin
            pend = 1'b0; wcnt = 0; prev_stall = 1'b0;
            avm_bus.avm_waitrequest = 1'b0;
         end else begin
            if (inject) begin
               avm_bus.avm_readdatavalid = 1'b1;
               avm_bus.avm_readdata      = 32'hA5A5_5A5A;
            end else if (pend) begin
               avm_bus.avm_readdatavalid = 1'b1;
               avm_bus.avm_readdata      = mem[paddr];
               pend = 1'b0;
            end
            if (avm_bus.avm_read) begin
               if (prev_stall) chk("addr_stable", {31'd0, avm_bus.avm_address}, {31'd0, prev_addr});
               if (wcnt < g_wait) begin
                  avm_bus.avm_waitrequest = 1'b1;
                  wcnt++;
                  prev_stall = 1'b1;
                  prev_addr  = avm_bus.avm_address;
               end else begin
                  avm_bus.avm_waitrequest = 1'b0;
                  wcnt = 0;
                  prev_stall = 1'b0;
                  if (!g_noresp[avm_bus.avm_address]) begin
                     pend  = 1'b1;
                     paddr = avm_bus.avm_address;
                  end
               end
            end else begin
               avm_bus.avm_waitrequest = 1'b0;
               prev_stall = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every done pulse.
   initial begin
      exp_t e;
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_done) begin
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
         end
         prev_done = 1'b0;
         if (!rst && done) begin
            ndone++;
            prev_done = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("latency", 32'(cyc - e.t0), 32'(e.lat));
               chk("busy_in_done", {31'd0, busy}, 32'd1);
               chk("sysid_id", sysid_id, e.id);
               chk("sysid_ts", sysid_ts, e.ts);
               chk("id_match", {31'd0, id_match}, {31'd0, e.idm});
               chk("ts_match", {31'd0, ts_match}, {31'd0, e.tsm});
               chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
            end
         end
      end
   end

   task automatic push_exp(input logic [31:0] id, input logic [31:0] ts, input logic idm,
                           input logic tsm, input logic to, input int lat);
      exp_t e;
      e.id = id; e.ts = ts; e.idm = idm; e.tsm = tsm; e.to = to; e.lat = lat; e.t0 = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s_completion actual=busy required=idle", name);
      end
      @(negedge clk);
   endtask

   // Called at a negedge with the DUT idle; that cycle is cycle 0.
   task automatic run_probe(input string name, input logic [31:0] id, input logic [31:0] ts,
                            input int wt, input logic idm, input logic tsm, input int lat);
      mem[0] = id; mem[1] = ts; g_wait = wt; g_noresp = 2'b00;
      push_exp(id, ts, idm, tsm, 1'b0, lat);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(name);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int nd0;
      checks = 0; errors = 0; cyc = 0; ndone = 0;
      rst = 1'b1; start = 1'b0; inject = 1'b0;
      g_wait = 0; g_noresp = 2'b00; mem[0] = '0; mem[1] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_read", {31'd0, avm_bus.avm_read}, 32'd0);
      chk("rst_addr", {31'd0, avm_bus.avm_address}, 32'd0);
      chk("rst_id", sysid_id, 32'd0);
      chk("rst_ts", sysid_ts, 32'd0);
      chk("rst_flags", {29'd0, id_match, ts_match, timeout_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_probe("basic", 32'd0, TS_GOOD, 0, 1'b1, 1'b1, 5);
      run_probe("stall3", 32'd0, TS_GOOD, 3, 1'b1, 1'b1, 11);
      run_probe("ts_off_by_one", 32'd0, 32'd1413707059, 0, 1'b1, 1'b0, 5);
      run_probe("bad_id", 32'hDEAD_BEEF, TS_GOOD, 0, 1'b0, 1'b1, 5);

      // Extra start pulses while busy, including in the DONE cycle, are ignored.
      nd0 = ndone;
      mem[0] = 32'd0; mem[1] = TS_GOOD; g_wait = 0;
      push_exp(32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 5);
      start = 1'b1; @(negedge clk);
      start = 1'b0; @(negedge clk);
      start = 1'b1; @(negedge clk);
      start = 1'b0; @(negedge clk);
      @(negedge clk);
      start = 1'b1; @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("start_while_busy_idle", {31'd0, busy}, 32'd0);
      chk("start_while_busy_ndone", 32'(ndone - nd0), 32'd1);
      wait_idle("busy_start");

`ifdef SYSID_PROBE_TIMEOUT_EN
      mem[0] = 32'h1111_2222; mem[1] = TS_GOOD; g_wait = 0; g_noresp = 2'b01;
      push_exp(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 9);
      start = 1'b1; @(negedge clk);
      start = 1'b0;
      wait_idle("timeout");
      @(posedge clk); inject = 1'b1;
      @(posedge clk); inject = 1'b0;
      repeat (3) @(negedge clk);
      chk("late_valid_id", sysid_id, 32'd0);
      chk("late_valid_busy", {31'd0, busy}, 32'd0);
      chk("late_valid_to", {31'd0, timeout_err}, 32'd1);
      g_noresp = 2'b00;
`endif

      // Reset while waiting for the timestamp, then a clean probe.
      mem[0] = 32'h1234_5678; mem[1] = TS_GOOD; g_wait = 0; g_noresp = 2'b10;
      start = 1'b1; @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("midprobe_busy", {31'd0, busy}, 32'd1);
      chk("midprobe_id", sysid_id, 32'h1234_5678);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_read", {31'd0, avm_bus.avm_read}, 32'd0);
      chk("rst2_busy", {31'd0, busy}, 32'd0);
      chk("rst2_id", sysid_id, 32'd0);
      chk("rst2_flags", {29'd0, id_match, ts_match, timeout_err}, 32'd0);
      rst = 1'b0;
      g_noresp = 2'b00;
      @(negedge clk);
      run_probe("after_reset", 32'd0, TS_GOOD, 1, 1'b1, 1'b1, 7);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysid_probe_master.md
# sysid_probe_master

Avalon-MM read master that interrogates the system-ID slave after reset or on software request. It reads the ID word (word address 0) and the build timestamp (word address 1), latches both, and compares them against build-time expected values. It sits beside the boot sequencer, and its match flags gate LED-tile pattern start-up.

## Interface
- `EXPECTED_ID`, default 0: expected value at word address 0.
- `EXPECTED_TS`, default 1413707058: expected value at word address 1.
- `TIMEOUT_CYCLES`, default 255: per-transaction watchdog limit, 1..65535.
- `clock` in 1: sole clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to run a probe. Ignored while `busy`=1.
- `avm_address` out 1: word address to the sysid slave.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall. The request is accepted on a cycle where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_readdata` in 32: read data.
- `avm_readdatavalid` in 1: qualifies `avm_readdata`.
- `busy` out 1: a probe is in progress.
- `done` out 1: one-cycle pulse when a probe ends, whether it passed, failed or timed out.
- `sysid_id` out 32: captured ID word.
- `sysid_ts` out 32: captured timestamp.
- `id_match` out 1: `sysid_id`==`EXPECTED_ID`.
- `ts_match` out 1: `sysid_ts`==`EXPECTED_TS`.
- `timeout_err` out 1: the last probe was aborted by the watchdog.

## Operation
- Reset values: all outputs are 0, and the state is IDLE.
- States and transitions:
  - IDLE. `start` moves to REQ_ID.
  - REQ_ID. Drives `avm_read`=1 and `avm_address`=0, both held stable until accepted. On acceptance moves to WAIT_ID.
  - WAIT_ID. On the first `avm_readdatavalid`, captures `avm_readdata` into `sysid_id` and moves to REQ_TS.
  - REQ_TS and WAIT_TS. Same as REQ_ID and WAIT_ID with address 1, capturing into `sysid_ts`.
  - DONE. Updates `id_match`/`ts_match`, pulses `done`, and returns to IDLE.
- `avm_readdatavalid` is sampled only in WAIT states. It is ignored in the acceptance cycle itself and in IDLE, which absorbs stray responses after an abort.
- `busy`=1 in every state except IDLE.
- On `start`, `sysid_id`, `sysid_ts`, the match flags and `timeout_err` all clear to 0.
- Results hold until the next `start` or `reset`.
- Comparisons are full 32-bit equality. No masking.
- A `start` asserted in the same cycle that DONE returns to IDLE is ignored. `start` is honoured only when the current state is IDLE.
- Reset mid-probe: `avm_read` drops at the same edge, the state goes to IDLE, and results clear.

## Timing
- Zero-wait slave with one-cycle read latency, `start` at cycle 0:
  - `avm_read` with address 0 at cycle 1.
  - `avm_readdatavalid` at cycle 2.
  - `avm_read` with address 1 at cycle 3.
  - `avm_readdatavalid` at cycle 4.
  - `done`, `busy`=0 transition and valid match flags at cycle 5.
  - Minimum probe length is 5 cycles after `start`.
- Each cycle of `avm_waitrequest`=1 extends the REQ state by one cycle.
- Each extra cycle of read latency extends the WAIT state by one cycle.
- The next `start` is accepted at the earliest in the cycle after `done`.

## Configuration
- `SYSID_PROBE_TIMEOUT_EN` defined: the watchdog is built in.
  - It counts cycles spent in the current REQ+WAIT pair and resets at each new transaction.
  - When the count reaches `TIMEOUT_CYCLES`, the probe aborts: `avm_read`=0 next cycle, `timeout_err`=1, match flags=0, `done` pulses.
  - Captured words that are already valid are retained.
- `SYSID_PROBE_TIMEOUT_EN` undefined: the master waits indefinitely, `timeout_err` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `sysid_probe_pkg` holds:
  - the state enum (IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE);
  - constants `SYSID_ADDR_ID`=1'b0 and `SYSID_ADDR_TS`=1'b1;
  - a 32-bit data typedef.
- One sub-module, `sysid_probe_watchdog`: a 16-bit counter with `clear`/`enable` inputs and an `expired` output. It is instantiated only under `SYSID_PROBE_TIMEOUT_EN`.

## Test plan
- Zero-wait slave, one-cycle latency, returning 0 then 1413707058 → `done` at cycle 5; `sysid_ts`=1413707058; `id_match`=1; `ts_match`=1; `timeout_err`=0.
- `avm_waitrequest` high for 3 cycles on each request → address and read held stable; `done` at cycle 11; correct data captured.
- Timestamp returns 1413707059 → `ts_match`=0, `id_match`=1, `done` pulses once.
- With `SYSID_PROBE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, slave never asserts `avm_readdatavalid` → `done` and `timeout_err`=1 at the 8th WAIT cycle; a late `avm_readdatavalid` in IDLE has no effect.
- `start` pulsed while `busy` → ignored; exactly one `done` pulse; data unchanged.
- `reset` asserted in WAIT_TS, then released and `start` applied → outputs all 0 after reset; new probe completes normally.
